// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the oversampling UART receive path.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
        longint den;
        den = baud * os;
        return int'((clk_hz + den / 64'sd2) / den);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit for a zero-extended word; odd mode inverts the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    function automatic bit params_ok(input int os, input int db, input int par,
                                     input int sb, input int div);
        return (os >= 8) && (os % 2 == 0) && (db >= 5) && (db <= 9) &&
               (par >= 0) && (par <= 2) && (sb >= 1) && (sb <= 2) && (div >= 2);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase reset by clr.
`timescale 1ns/1ps
module uart_os_tick
    import uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    // Next divider count and registered tick
    always_comb begin
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {W{1'b0}};
        end else begin
            cnt_d = cnt_q + W'(1);
        end
        tick_d = !clr && (cnt_d == LAST);
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= {W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, parity/framing checks
// and a valid/ready output register that flags overrun on a dropped frame.
`timescale 1ns/1ps
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_frame_err,
    output logic                 m_parity_err,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 overrun,
    output logic                 busy
);
    localparam int DIV = calc_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int H   = OVERSAMPLE / 2;
    localparam logic [CW-1:0] SAMP_A    = CW'(H - 1);
    localparam logic [CW-1:0] SAMP_B    = CW'(H);
    localparam logic [CW-1:0] SAMP_C    = CW'(H + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam parity_e       PAR_MODE  = parity_e'(2'(PARITY));

    if (!params_ok(OVERSAMPLE, DATA_BITS, PARITY, STOP_BITS, DIV)) begin : g_param_err
        $error("uart_rx_os: illegal parameter combination");
    end

    logic [1:0]           sync_q, sync_d;
    logic                 prev_q, prev_d;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic                 s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, done_q, done_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 m_ferr_q, m_ferr_d, m_perr_q, m_perr_d;
    logic                 m_valid_q, m_valid_d, overrun_q, overrun_d, busy_q, busy_d;

    logic rxs, tick, tick_clr, voted, vote_now, wrap, ferr_now;

    assign rxs      = sync_q[1];
    assign tick_clr = (state_q == IDLE);

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Receive FSM: synchroniser, sample capture, majority vote and frame sequencing
    always_comb begin
        sync_d   = {sync_q[0], rx};
        prev_d   = rxs;
        state_d  = state_q;
        idx_d    = idx_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        done_d   = 1'b0;
        voted    = maj3(s0_q, s1_q, rxs);
        vote_now = tick && (cnt_q == SAMP_C);
        wrap     = tick && (cnt_q == CNT_LAST);
        ferr_now = ferr_q | ~voted;

        if (tick) begin
            cnt_d = wrap ? {CW{1'b0}} : cnt_q + CW'(1);
            if (cnt_q == SAMP_A) begin
                s0_d = rxs;
            end else if (cnt_q == SAMP_B) begin
                s1_d = rxs;
            end else begin
                s0_d = s0_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = {CW{1'b0}};
                idx_d = 4'd0;
                if (prev_q && !rxs) begin
                    state_d = START;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (vote_now && voted) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (vote_now) begin
                    shift_d = {voted, shift_q[DATA_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (wrap && idx_q == DATA_LAST) begin
                    idx_d   = 4'd0;
                    state_d = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end else if (wrap) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    idx_d = idx_q;
                end
            end
            uart_pkg::PARITY: begin
                if (vote_now) begin
                    perr_d = voted != parity_bit(9'(shift_q), PAR_MODE == PAR_ODD);
                end else begin
                    perr_d = perr_q;
                end
                if (wrap) begin
                    state_d = STOP;
                end else begin
                    state_d = uart_pkg::PARITY;
                end
            end
            STOP: begin
                // The last stop bit completes at its final sample so a following
                // start edge can be caught without waiting for the bit end.
                if (vote_now && idx_q == STOP_LAST) begin
                    ferr_d  = ferr_now;
                    done_d  = 1'b1;
                    state_d = ferr_now ? WAIT_IDLE : IDLE;
                end else if (vote_now) begin
                    ferr_d = ferr_now;
                end else if (wrap) begin
                    idx_d = idx_q + 4'd1;
                end else begin
                    state_d = STOP;
                end
            end
            WAIT_IDLE: begin
                if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Output holding register with overrun detection
    always_comb begin
        m_data_d  = m_data_q;
        m_ferr_d  = m_ferr_q;
        m_perr_d  = m_perr_q;
        m_valid_d = m_valid_q;
        overrun_d = 1'b0;
        if (done_q) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = shift_q;
                m_ferr_d  = ferr_q;
                m_perr_d  = perr_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            idx_q     <= 4'd0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            shift_q   <= {DATA_BITS{1'b0}};
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
            m_data_q  <= {DATA_BITS{1'b0}};
            m_ferr_q  <= 1'b0;
            m_perr_q  <= 1'b0;
            m_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
            m_data_q  <= m_data_d;
            m_ferr_q  <= m_ferr_d;
            m_perr_q  <= m_perr_d;
            m_valid_q <= m_valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_frame_err  = m_ferr_q;
    assign m_parity_err = m_perr_q;
    assign m_valid      = m_valid_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three instances cover 8N1, 8E1 and 7O2 framing.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CLK_NS = 20;
    localparam int BIT_NS = 8680;
    localparam int GAP_NS = BIT_NS / 4;
    localparam int DIV    = 27;
    localparam int OS     = 16;
    localparam int H      = OS / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic m_ready = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic ferr0, perr0, valid0, ovr0, busy0;
    logic ferr1, perr1, valid1, ovr1, busy1;
    logic ferr2, perr2, valid2, ovr2, busy2;

    typedef struct packed {
        logic [1:0] id;
        logic [8:0] d;
        logic       f;
        logic       p;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int ovr0_cnt = 0, ovr1_cnt = 0, ovr2_cnt = 0;

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx_os u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .m_data(data0), .m_frame_err(ferr0),
        .m_parity_err(perr0), .m_valid(valid0), .m_ready(m_ready), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_os #(.PARITY(2)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .m_data(data1), .m_frame_err(ferr1),
        .m_parity_err(perr1), .m_valid(valid1), .m_ready(m_ready), .overrun(ovr1), .busy(busy1)
    );

    uart_rx_os #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(1)) u_dut2 (
        .clk(clk), .rst(rst), .rx(rx2), .m_data(data2), .m_frame_err(ferr2),
        .m_parity_err(perr2), .m_valid(valid2), .m_ready(m_ready), .overrun(ovr2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input logic [1:0] id, input logic [8:0] d, input logic f, input logic p);
        exp_t e;
        e.id = id;
        e.d  = d;
        e.f  = f;
        e.p  = p;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] id, input logic [8:0] d, input logic f, input logic p);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_beat", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_id", 32'(id), 32'(e.id));
            check("sb_data", 32'(d), 32'(e.d));
            check("sb_frame_err", 32'(f), 32'(e.f));
            check("sb_parity_err", 32'(p), 32'(e.p));
        end
    endtask

    // Handshake monitors: every accepted beat is matched against the scoreboard
    always @(negedge clk) if (rst && valid0 && m_ready) sb_pop(2'd0, 9'(data0), ferr0, perr0);
    always @(negedge clk) if (rst && valid1 && m_ready) sb_pop(2'd1, 9'(data1), ferr1, perr1);
    always @(negedge clk) if (rst && valid2 && m_ready) sb_pop(2'd2, 9'(data2), ferr2, perr2);
    always @(negedge clk) if (ovr0) ovr0_cnt++;
    always @(negedge clk) if (ovr1) ovr1_cnt++;
    always @(negedge clk) if (ovr2) ovr2_cnt++;

    task automatic set_rx(input int id, input logic v);
        case (id)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // gbit >= 0 flips that data bit for one clock at the receiver's middle sample.
    task automatic send_frame(input int id, input logic [8:0] d, input int nbits,
                              input bit has_par, input logic par_bit, input int nstop,
                              input logic [1:0] stop_v, input int gbit, input logic idle_v);
        @(negedge clk);
        set_rx(id, 1'b0);
        #(BIT_NS);
        for (int b = 0; b < nbits; b++) begin
            set_rx(id, d[b]);
            if (b == gbit) begin
                int off;
                off = DIV * CLK_NS * (OS * (b + 1) + H + 1) - BIT_NS * (b + 1);
                #(off);
                set_rx(id, ~d[b]);
                #(CLK_NS);
                set_rx(id, d[b]);
                #(BIT_NS - off - CLK_NS);
            end else begin
                #(BIT_NS);
            end
        end
        if (has_par) begin
            set_rx(id, par_bit);
            #(BIT_NS);
        end
        for (int s = 0; s < nstop; s++) begin
            set_rx(id, stop_v[s]);
            #(BIT_NS);
        end
        set_rx(id, idle_v);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_valid0", 32'(valid0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_data0", 32'(data0), 32'd0);
        check("rst_ferr0", 32'(ferr0), 32'd0);
        check("rst_perr0", 32'(perr0), 32'd0);
        check("rst_ovr0", 32'(ovr0), 32'd0);
        check("rst_valid1", 32'(valid1), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);

        // Back-to-back clean frames; the second carries a one-clock flip at a sample point
        m_ready = 1'b1;
        expect_word(2'd0, 9'h054, 1'b0, 1'b0);
        send_frame(0, 9'h054, 8, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        #(GAP_NS);
        expect_word(2'd0, 9'h02C, 1'b0, 1'b0);
        send_frame(0, 9'h02C, 8, 1'b0, 1'b0, 1, 2'b11, 3, 1'b1);
        #(GAP_NS);
        check("clean_drain", 32'(sb_q.size()), 32'd0);
        check("clean_no_overrun", 32'(ovr0_cnt), 32'd0);

        // Framing error followed by a break
        expect_word(2'd0, 9'h03C, 1'b1, 1'b0);
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b00, -1, 1'b0);
        #(20 * BIT_NS);
        check("break_busy", 32'(busy0), 32'd1);
        check("break_drain", 32'(sb_q.size()), 32'd0);
        rx0 = 1'b1;
        repeat (6) @(negedge clk);
        check("break_release_busy", 32'(busy0), 32'd0);

        // Short low glitch on an idle line
        @(negedge clk);
        rx0 = 1'b0;
        #(3 * CLK_NS);
        rx0 = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_busy", 32'(busy0), 32'd1);
        #(BIT_NS);
        check("glitch_idle", 32'(busy0), 32'd0);
        check("glitch_no_valid", 32'(valid0), 32'd0);

        // Overrun: consumer stalled across two frames
        @(posedge clk);
        #1 m_ready = 1'b0;
        expect_word(2'd0, 9'h011, 1'b0, 1'b0);
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        #(GAP_NS);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        #(GAP_NS);
        check("ovr_count", 32'(ovr0_cnt), 32'd1);
        check("ovr_hold_valid", 32'(valid0), 32'd1);
        check("ovr_hold_data", 32'(data0), 32'h11);
        @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_drain", 32'(sb_q.size()), 32'd0);
        check("ovr_valid_low", 32'(valid0), 32'd0);

        // Even parity: wrong then right parity bit
        expect_word(2'd1, 9'h0A5, 1'b0, 1'b1);
        send_frame(1, 9'h0A5, 8, 1'b1, 1'b1, 1, 2'b11, -1, 1'b1);
        #(GAP_NS);
        expect_word(2'd1, 9'h0A5, 1'b0, 1'b0);
        send_frame(1, 9'h0A5, 8, 1'b1, 1'b0, 1, 2'b11, -1, 1'b1);
        #(GAP_NS);
        check("even_drain", 32'(sb_q.size()), 32'd0);

        // 7 data bits, odd parity, two stop bits
        expect_word(2'd2, 9'h055, 1'b0, 1'b0);
        send_frame(2, 9'h055, 7, 1'b1, 1'b1, 2, 2'b11, -1, 1'b1);
        #(GAP_NS);
        expect_word(2'd2, 9'h055, 1'b1, 1'b0);
        send_frame(2, 9'h055, 7, 1'b1, 1'b1, 2, 2'b01, -1, 1'b1);
        #(GAP_NS);
        check("7o2_drain", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a data bit, then a clean frame
        @(negedge clk);
        rx0 = 1'b0;
        #(3 * BIT_NS + BIT_NS / 2);
        check("midrst_pre_busy", 32'(busy0), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        rx0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_valid", 32'(valid0), 32'd0);
        check("midrst_data", 32'(data0), 32'd0);
        check("midrst_ferr", 32'(ferr0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #(BIT_NS);
        expect_word(2'd0, 9'h07E, 1'b0, 1'b0);
        send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        #(GAP_NS);
        check("final_drain", 32'(sb_q.size()), 32'd0);
        check("final_ovr0", 32'(ovr0_cnt), 32'd1);
        check("final_ovr12", 32'(ovr1_cnt + ovr2_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver; next generation of the receive path behind the loopback command parser.
- Adds configurable data width, parity mode, stop-bit count and 3-sample majority voting.
- Reports per-frame framing/parity errors and overrun, and delivers words over a valid/ready handshake to the parser or a FIFO.
- Sits between the pad-level rx pin and any byte consumer.

Parameters:
- CLOCK_FREQUENCY, 50_000_000, system clock in Hz
- BAUD_RATE, 115200, line rate in bit/s
- OVERSAMPLE, 16, ticks per bit; even, >= 8
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset)
- rx  input  1  asynchronous serial line, idle high
- m_data  output  DATA_BITS  received word, LSB = first bit on line
- m_frame_err  output  1  stop bit(s) sampled low for this word
- m_parity_err  output  1  parity mismatch for this word (0 when PARITY=0)
- m_valid  output  1  word and flags valid
- m_ready  input  1  consumer accepts word when m_valid & m_ready
- overrun  output  1  one-cycle pulse: completed frame dropped
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: m_data=0, m_frame_err=0, m_parity_err=0, m_valid=0, overrun=0, busy=0, synchroniser=11, state=IDLE. Reset mid-frame aborts it with no output.
- rx passes through a 2-FF synchroniser (reset value 1); all logic uses the synchronised value rxs.
- Tick generator: DIV = round(CLOCK_FREQUENCY/(BAUD_RATE*OVERSAMPLE)); default 27. Emits a 1-cycle tick every DIV clocks. Held at 0 in IDLE; restarts on start detection so phase aligns to the start edge.
- Within a bit, a counter cnt runs 0..OVERSAMPLE-1 on ticks. Samples are taken at cnt = H-1, H, H+1, with H = OVERSAMPLE/2. Bit value = majority of the 3 samples.
- IDLE: falling edge on rxs (prev 1, now 0) -> START.
- START: voted value 1 -> false start, back to IDLE, no output. Voted 0 -> DATA at cnt wrap.
- DATA: DATA_BITS bits shifted in LSB first. After the last bit -> PARITY if PARITY != 0, else STOP.
- PARITY: expected bit = XOR of data, inverted for odd parity. Mismatch sets the parity_err flag.
- STOP: STOP_BITS bits; any voted 0 sets frame_err. Completion happens at the final stop bit's H+1 sample, not at the bit end, to allow early resync.
- Completion when m_valid=0: next clock m_data/flags load and m_valid=1.
- Completion when m_valid=1 and no handshake that cycle: overrun pulses 1 cycle; new word discarded; old word and flags unchanged.
- Handshake and completion in the same cycle: old word accepted and new word loaded; m_valid stays 1; no overrun.
- m_valid falls the cycle after m_valid & m_ready unless a reload occurs. m_data and flags are stable while m_valid & !m_ready.
- After completion with frame_err=1: go to WAIT_IDLE until rxs=1, then IDLE. This prevents re-triggering on a break condition. Otherwise go straight to IDLE.
- Frames with errors are still delivered, flags attached.
- Latency: m_valid rises 2 clocks after the final stop-bit H+1 tick (1 register stage plus output load), plus 2 clocks of synchroniser delay measured from the pin.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE)
  - function calc_div(clk_hz, baud, os) with rounding
  - elaboration-time assertions on parameter ranges
- One sub-module: uart_os_tick, the divider/tick generator with a synchronous clear input.
- Synchroniser, majority vote and FSM stay in uart_rx_os.

Test Plan:
- Defaults, 8680 ns bit period, send 0x54 then 0x2C with m_ready=1 -> two m_valid beats carrying 0x54 then 0x2C, both error flags 0, no overrun.
- PARITY=2, send 0xA5 with parity bit 1 -> m_data=0xA5, m_parity_err=1. Same frame with parity bit 0 -> m_parity_err=0.
- Send 0x3C with stop bit driven 0, then hold rx low 20 bit periods -> exactly one beat: 0x3C, m_frame_err=1. busy stays high until rx returns high; no further frames.
- 3-clock low glitch on idle rx -> false start, busy returns to 0, no m_valid. A single-clock flip at sample point H inside a data bit -> majority restores the correct value.
- m_ready=0, send 0x11 then 0x22 -> m_data holds 0x11, overrun pulses once at the second completion. After m_ready=1, 0x11 is accepted and 0x22 never appears.
- DATA_BITS=7, STOP_BITS=2, PARITY=1, send 0x55 -> m_data=7'h55, no errors. Second stop bit low -> m_frame_err=1.
- Additional check: assert rst=0 mid-DATA -> all outputs return to reset values next clock; the following clean frame 0x7E is received correctly.
